// File: rtl/am2910_seq_ctrl_if.sv
// rtl/am2910_seq_ctrl_if.sv - sequencer-to-LIFO stack handshake bundle
interface am2910_seq_ctrl_if #(
    parameter int AW = 12
);
    logic          stk_push;
    logic          stk_pop;
    logic          stk_clear;
    logic [AW-1:0] stk_din;
    logic [AW-1:0] stk_top;
    logic          stk_full;
    logic          stk_empty;

    modport master (
        output stk_push, stk_pop, stk_clear, stk_din,
        input  stk_top, stk_full, stk_empty
    );

    modport slave (
        input  stk_push, stk_pop, stk_clear, stk_din,
        output stk_top, stk_full, stk_empty
    );
endinterface

// File: rtl/am2910_seq_ctrl.sv
// rtl/am2910_seq_ctrl.sv - AM2910-style next-address control core (uPC, R, stack strobes)
module am2910_seq_ctrl #(
    parameter int AW = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           instr,
    input  logic [AW-1:0]        d_in,
    input  logic                 ccen_n,
    input  logic                 cc_n,
    input  logic                 rld_n,
    input  logic                 ci,
    output logic [AW-1:0]        y,
    am2910_seq_ctrl_if.master    stk,
    output logic                 pl_n,
    output logic                 map_n,
    output logic                 vect_n,
    output logic                 full_n
);

    typedef enum logic [3:0] {
        I_JZ   = 4'd0,  I_CJS  = 4'd1,  I_JMAP = 4'd2,  I_CJP  = 4'd3,
        I_PUSH = 4'd4,  I_JSRP = 4'd5,  I_CJV  = 4'd6,  I_JRP  = 4'd7,
        I_RFCT = 4'd8,  I_RPCT = 4'd9,  I_CRTN = 4'd10, I_CJPP = 4'd11,
        I_LDCT = 4'd12, I_LOOP = 4'd13, I_CONT = 4'd14, I_TWB  = 4'd15
    } instr_e;

    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] upc_q, upc_d;
    logic [AW-1:0] r_q, r_d;
    instr_e        op;
    logic          pass, rz;
    logic          push_req, pop_req, r_load, r_dec;

    assign op   = instr_e'(instr);
    assign pass = ccen_n | ~cc_n;
    assign rz   = (r_q == '0);

    always_comb begin
        y         = upc_q;
        push_req  = 1'b0;
        pop_req   = 1'b0;
        stk.stk_clear = 1'b0;
        r_load    = 1'b0;
        r_dec     = 1'b0;
        pl_n      = 1'b0;
        map_n     = 1'b1;
        vect_n    = 1'b1;
        if (reset) begin
            y             = '0;
            stk.stk_clear = 1'b1;
        end else begin
            unique case (op)
                I_JZ: begin
                    y             = '0;
                    stk.stk_clear = 1'b1;
                end
                I_CJS:  if (pass) begin y = d_in; push_req = 1'b1; end
                I_JMAP: begin y = d_in; pl_n = 1'b1; map_n = 1'b0; end
                I_CJP:  if (pass) y = d_in;
                I_PUSH: begin push_req = 1'b1; r_load = pass; end
                I_JSRP: begin push_req = 1'b1; y = pass ? d_in : r_q; end
                I_CJV: begin
                    if (pass) y = d_in;
                    pl_n   = 1'b1;
                    vect_n = 1'b0;
                end
                I_JRP:  y = pass ? d_in : r_q;
                I_RFCT: if (!rz) begin y = stk.stk_top; r_dec = 1'b1; end
                        else pop_req = 1'b1;
                I_RPCT: if (!rz) begin y = d_in; r_dec = 1'b1; end
                I_CRTN: if (pass) begin y = stk.stk_top; pop_req = 1'b1; end
                I_CJPP: if (pass) begin y = d_in; pop_req = 1'b1; end
                I_LDCT: r_load = 1'b1;
                I_LOOP: if (pass) pop_req = 1'b1;
                        else y = stk.stk_top;
                I_CONT: y = upc_q;
                I_TWB: begin
                    // Only the counting-down failure case keeps the loop entry on the stack
                    if (!rz && !pass) begin
                        y     = stk.stk_top;
                        r_dec = 1'b1;
                    end else begin
                        pop_req = 1'b1;
                        if (rz && !pass) y = d_in;
                    end
                end
                default: y = upc_q;
            endcase
        end
    end

    assign stk.stk_push = push_req & ~stk.stk_full;
    assign stk.stk_pop  = pop_req & ~stk.stk_empty & ~push_req;
    assign stk.stk_din  = upc_q;
    assign full_n       = ~stk.stk_full;

    always_comb begin
        upc_d = y + {{(AW-1){1'b0}}, ci};
        r_d   = r_q;
        if (reset)
            r_d = '0;
        else if (!rld_n || r_load)
            r_d = d_in;
        else if (r_dec)
            r_d = r_q - ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            upc_q <= '0;
            r_q   <= '0;
        end else begin
            upc_q <= upc_d;
            r_q   <= r_d;
        end
    end

endmodule

// File: doc/am2910_seq_ctrl.md
Name: am2910_seq_ctrl

Overview:
- Next-address control core of the AM2910-style microprogram sequencer.
- Decodes the 4-bit instruction and drives the push, pop and clear inputs of the 12-bit LIFO stack.
- Reads that stack's top and its full/empty flags.
- Holds the microprogram counter (uPC) and the register/counter (R), and produces the next microaddress Y.

Parameters:
- AW, 12, address/data width; must match the stack width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instr  in  4  instruction code I[3:0]
- d_in  in  AW  direct/branch input D
- ccen_n  in  1  condition-code enable, active low
- cc_n  in  1  condition code, active low
- rld_n  in  1  R load strobe, active low
- ci  in  1  uPC increment carry-in
- y  out  AW  next microaddress (combinational)
- stk_push  out  1  stack push enable
- stk_pop  out  1  stack pop enable
- stk_clear  out  1  stack clear
- stk_din  out  AW  stack push data; always equals uPC
- stk_top  in  AW  current stack top (combinational from stack)
- stk_full  in  1  stack full
- stk_empty  in  1  stack empty
- pl_n, map_n, vect_n  out  1 each  source-enable strobes, active low; exactly one low per cycle
- full_n  out  1  inverted stk_full

Behaviour:
- Condition pass: PASS = ccen_n | ~cc_n.
- RZ = (R == 0).
- y is combinational from the current state and inputs.
- Register updates at each clk edge:
  - uPC <= y + ci, modulo 2^AW.
  - If rld_n == 0, R <= d_in; this overrides all instruction effects on R.
- Instruction decode (Y source / stack action / R action). Every unlisted output defaults to y = uPC, no stack operation, R held, pl_n low.
  - 0 JZ: y=0; stk_clear=1.
  - 1 CJS: PASS: y=d_in, push. Else: y=uPC.
  - 2 JMAP: y=d_in; map_n low.
  - 3 CJP: PASS: y=d_in. Else: y=uPC.
  - 4 PUSH: push. If PASS, R<=d_in. y=uPC.
  - 5 JSRP: push always. y = PASS ? d_in : R.
  - 6 CJV: PASS: y=d_in. Else: y=uPC. vect_n low.
  - 7 JRP: y = PASS ? d_in : R.
  - 8 RFCT: if !RZ: y=stk_top, R<=R-1. Else: y=uPC, pop.
  - 9 RPCT: if !RZ: y=d_in, R<=R-1. Else: y=uPC.
  - 10 CRTN: PASS: y=stk_top, pop. Else: y=uPC.
  - 11 CJPP: PASS: y=d_in, pop. Else: y=uPC.
  - 12 LDCT: R<=d_in; y=uPC.
  - 13 LOOP: PASS: y=uPC, pop. Else: y=stk_top.
  - 14 CONT: y=uPC.
  - 15 TWB:
    - !RZ and fail: y=stk_top, R<=R-1.
    - !RZ and pass: y=uPC, pop.
    - RZ and fail: y=d_in, pop.
    - RZ and pass: y=uPC, pop.
- Stack boundary rules:
  - stk_push is gated by ~stk_full; a push while full is dropped and uPC is not stored.
  - stk_pop is gated by ~stk_empty.
  - y = stk_top is still used when the stack is empty; the stack defines its empty-top value.
  - stk_push and stk_pop are never asserted together.
  - stk_clear is exclusive with push and pop.
- Stack handshake:
  - Push data is the uPC value present before the edge.
  - The stack samples push, pop and clear on the same edge.
- Reset (reset=1):
  - y=0, stk_push=0, stk_pop=0, stk_clear=1.
  - pl_n=0, map_n=1, vect_n=1.
  - uPC<=0, R<=0 at the edge.
  - A reset mid-subroutine empties the stack through stk_clear.
- R decrement wraps modulo 2^AW. Decrement is never applied when RZ.

Test Plan:
- Reset, then CONT x3 with ci=1 -> y = 0,1,2; uPC=3; no stack strobes.
- uPC=0x010, CJS, cc_n=0, ccen_n=0, d_in=0xAAA -> y=0xAAA, stk_push=1, stk_din=0x010. Next cycle CRTN pass with stk_top=0x010 -> y=0x010, stk_pop=1.
- LDCT with d_in=0x002, then RPCT with d_in=0x100 x3 -> y = 0x100, 0x100, then uPC; R goes 2 -> 1 -> 0.
- CJS pass x6 with stk_full rising after the 5th push -> 6th cycle stk_push=0, y=d_in.
- CRTN pass with stk_empty=1 -> stk_pop=0, y=stk_top. Then JZ -> y=0, stk_clear=1.
- TWB with R=1, fail, stk_top=0x055 -> y=0x055, R=0. Next TWB fail, d_in=0x300 -> y=0x300, pop. Also rld_n=0 during RFCT -> R=d_in (rld_n wins).
